hazard_unit: RTL and testbench

// - Parametrised forwarding/stall/flush controller for the in-order fetch->execute->write pipeline.
// - Supersedes the single-stage lastRD compare: tracks N_STAGES in-flight writers, selects the youngest forwarding source per operand.
// - Stalls on load-use, flushes on taken branch.
// - Sits beside fetch; its outputs steer the decode/execute pipeline register and the execute operand muxes.

---
 rtl/fewcore_pkg.sv | 16 +
 rtl/hazard_scoreboard.sv | 60 ++++++
 rtl/hazard_unit.sv | 120 ++++++++++++
 tb/tb_hazard_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fewcore_pkg.sv
// rtl/fewcore_pkg.sv - shared types and constants for the fewcore pipeline control
package fewcore_pkg;

  // Default architectural register index width (16 registers)
  localparam int HZ_REG_AW_DEF = 4;

  // Forwarding select value meaning "read the register file"
  localparam int FWD_REGFILE = 0;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_STALL,
    HZ_FLUSH
  } hz_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer shift register with per-stage source match vectors
module hazard_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int N_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ins_en,
  input  logic [REG_AW-1:0]   ins_rd,
  input  logic                ins_we,
  input  logic                ins_ld,
  input  logic [REG_AW-1:0]   rs1,
  input  logic [REG_AW-1:0]   rs2,
  output logic [N_STAGES-1:0] hit_rs1,
  output logic [N_STAGES-1:0] hit_rs2,
  output logic [N_STAGES-1:0] ld_vec
);

  // Bit/element k holds stage k+1 (element 0 = execute)
  logic [N_STAGES-1:0] v_q;
  logic [N_STAGES-1:0] we_q;
  logic [N_STAGES-1:0] ld_q;
  logic [REG_AW-1:0]   rd_q [N_STAGES];

  // Advance every entry one stage; a non-inserted slot enters as invalid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      we_q <= '0;
      ld_q <= '0;
      for (int k = 0; k < N_STAGES; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q[0]  <= ins_en;
      we_q[0] <= ins_we;
      ld_q[0] <= ins_ld;
      rd_q[0] <= ins_rd;
      for (int k = 1; k < N_STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        we_q[k] <= we_q[k-1];
        ld_q[k] <= ld_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
    end
  end

  // Raw per-stage matches; zero-register masking is applied by the consumer
  always_comb begin
    hit_rs1 = '0;
    hit_rs2 = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      hit_rs1[k] = v_q[k] & we_q[k] & (rd_q[k] == rs1);
      hit_rs2[k] = v_q[k] & we_q[k] & (rd_q[k] == rs2);
    end
  end

  assign ld_vec = ld_q & v_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding select, load-use stall and branch flush controller
module hazard_unit
  import fewcore_pkg::*;
#(
  parameter int REG_AW    = HZ_REG_AW_DEF,
  parameter int N_STAGES  = 2,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int ZERO_REG  = 1,
  localparam int SELW     = $clog2(N_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_we,
  input  logic              dec_is_load,
  input  logic              branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [SELW-1:0]   fwd_rs1,
  output logic [SELW-1:0]   fwd_rs2
);

  // The branch cycle itself kills one slot; the counter covers the rest
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYC - 1);

  logic [N_STAGES-1:0] hit_rs1, hit_rs2, ld_vec;
  logic [N_STAGES-1:0] m_rs1, m_rs2, ld_win;
  logic                stall_req, ins_en;
  hz_state_t           state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .N_STAGES (N_STAGES)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .ins_en  (ins_en),
    .ins_rd  (dec_rd),
    .ins_we  (dec_we),
    .ins_ld  (dec_is_load),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .hit_rs1 (hit_rs1),
    .hit_rs2 (hit_rs2),
    .ld_vec  (ld_vec)
  );

  // Mask hard-wired zero register and build the load-not-ready window
  always_comb begin
    m_rs1  = hit_rs1 & {N_STAGES{!((ZERO_REG != 0) && (dec_rs1 == '0))}};
    m_rs2  = hit_rs2 & {N_STAGES{!((ZERO_REG != 0) && (dec_rs2 == '0))}};
    ld_win = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      ld_win[k] = (k < LOAD_LAT);
    end
    stall_req = dec_valid & (|((m_rs1 | m_rs2) & ld_vec & ld_win));
  end

  // Youngest matching stage wins: scan oldest to youngest, last hit sticks
  always_comb begin
    fwd_rs1 = SELW'(FWD_REGFILE);
    fwd_rs2 = SELW'(FWD_REGFILE);
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (m_rs1[k]) fwd_rs1 = SELW'(k + 1);
      if (m_rs2[k]) fwd_rs2 = SELW'(k + 1);
    end
  end

  // Flush dominates stall; nothing enters the scoreboard while either is active
  always_comb begin
    flush  = !reset & (branch_taken | (state_q == HZ_FLUSH));
    stall  = stall_req & !flush;
    bubble = stall;
    ins_en = dec_valid & !stall & !flush;
  end

  // State and flush counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: branch_taken > flush in progress > load-use stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      if (FLUSH_RELOAD != 2'd0) begin
        state_d = HZ_FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = HZ_RUN;
        cnt_d   = 2'd0;
      end
    end else if (state_q == HZ_FLUSH) begin
      if (cnt_q <= 2'd1) begin
        state_d = HZ_RUN;
        cnt_d   = 2'd0;
      end else begin
        cnt_d   = cnt_q - 2'd1;
      end
    end else if (stall_req) begin
      state_d = HZ_STALL;
    end else begin
      state_d = HZ_RUN;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic [3:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_we, dec_is_load, branch_taken;
  logic       stall, bubble, flush;
  logic [1:0] fwd_rs1, fwd_rs2;

  int n_cmp = 0;
  int n_err = 0;

  hazard_unit #(
    .REG_AW    (4),
    .N_STAGES  (2),
    .LOAD_LAT  (1),
    .FLUSH_CYC (2),
    .ZERO_REG  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .dec_we       (dec_we),
    .dec_is_load  (dec_is_load),
    .branch_taken (branch_taken),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic we, input logic ld, input logic br);
    dec_valid    = v;
    dec_rs1      = rs1;
    dec_rs2      = rs2;
    dec_rd       = rd;
    dec_we       = we;
    dec_is_load  = ld;
    branch_taken = br;
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic s, input logic b, input logic f);
    check_eq({tag, ".stall"},  {31'd0, stall},  {31'd0, s});
    check_eq({tag, ".bubble"}, {31'd0, bubble}, {31'd0, b});
    check_eq({tag, ".flush"},  {31'd0, flush},  {31'd0, f});
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_eq("reset.fwd_rs1", 32'(fwd_rs1), 32'd0);
    check_eq("reset.fwd_rs2", 32'(fwd_rs2), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // I0: rd=3 ALU
    drive(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    check_eq("i0.fwd_rs1", 32'(fwd_rs1), 32'd0);
    @(negedge clk);
    // I1: rs1=3 back-to-back, unrelated rd=6
    drive(1'b1, 4'd3, 4'd4, 4'd6, 1'b1, 1'b0, 1'b0);
    check_eq("b2b.fwd_rs1", 32'(fwd_rs1), 32'd1);
    check_eq("b2b.fwd_rs2", 32'(fwd_rs2), 32'd0);
    @(negedge clk);
    // I2: rs2=3 one instruction later
    drive(1'b1, 4'd0, 4'd3, 4'd8, 1'b1, 1'b0, 1'b0);
    check_eq("gap.fwd_rs2", 32'(fwd_rs2), 32'd2);
    check_eq("gap.fwd_rs1", 32'(fwd_rs1), 32'd0);
    @(negedge clk);

    // Youngest wins: rd=5 twice, then read 5
    drive(1'b1, 4'd1, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd9, 4'd10, 4'd5, 1'b1, 1'b0, 1'b0);
    check_eq("nohit.fwd_rs1", 32'(fwd_rs1), 32'd0);
    @(negedge clk);
    drive(1'b1, 4'd5, 4'd5, 4'd11, 1'b1, 1'b0, 1'b0);
    check_eq("young.fwd_rs1", 32'(fwd_rs1), 32'd1);
    check_eq("young.fwd_rs2", 32'(fwd_rs2), 32'd1);
    @(negedge clk);

    // Load-use: load rd=7, then rs2=7
    drive(1'b1, 4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0);
    check_ctl("ld", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd1, 4'd7, 4'd12, 1'b1, 1'b0, 1'b0);
    check_ctl("lu1", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_ctl("lu2", 1'b0, 1'b0, 1'b0);
    check_eq("lu2.fwd_rs2", 32'(fwd_rs2), 32'd2);
    @(negedge clk);

    // Zero register: load to x0, then read x0
    drive(1'b1, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_eq("x0.fwd_rs1", 32'(fwd_rs1), 32'd0);
    check_eq("x0.fwd_rs2", 32'(fwd_rs2), 32'd0);
    check_ctl("x0", 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Branch during load-use stall, FLUSH_CYC=2
    drive(1'b1, 4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 4'd7, 4'd2, 4'd13, 1'b1, 1'b0, 1'b1);
    check_ctl("br1", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 4'd7, 4'd2, 4'd13, 1'b1, 1'b0, 1'b0);
    check_ctl("br2", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 4'd7, 4'd13, 4'd3, 1'b1, 1'b0, 1'b0);
    check_ctl("br3", 1'b0, 1'b0, 1'b0);
    check_eq("br3.fwd_rs1", 32'(fwd_rs1), 32'd0);
    check_eq("br3.fwd_rs2", 32'(fwd_rs2), 32'd0);
    @(negedge clk);

    // Async reset in the middle of a flush
    drive(1'b1, 4'd1, 4'd2, 4'd14, 1'b1, 1'b0, 1'b1);
    check_ctl("rf1", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 4'd3, 4'd2, 4'd14, 1'b1, 1'b0, 1'b0);
    check_ctl("rf2", 1'b0, 1'b0, 1'b1);
    check_eq("rf2.fwd_rs1", 32'(fwd_rs1), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_ctl("arst", 1'b0, 1'b0, 1'b0);
    check_eq("arst.fwd_rs1", 32'(fwd_rs1), 32'd0);
    check_eq("arst.fwd_rs2", 32'(fwd_rs2), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4'd3, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0);
    check_ctl("post", 1'b0, 1'b0, 1'b0);
    check_eq("post.fwd_rs1", 32'(fwd_rs1), 32'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
